// File: rtl/pcfa2c_prefix_adder.sv
// ============================================================================
// Module   : pcfa2c_prefix_adder
// Brief    : Registered WIDTH-bit adder (A + B + Cin) built on a Kogge-Stone
//            carry tree; optional Cout/Ovf/Zero flags under PCFA2C_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pcfa2c_prefix_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int c_LEVELS = $clog2(WIDTH);

    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;

    assign w_p0 = A ^ B;

    // Cin is absorbed into bit 0 so that log2(WIDTH) levels span the full
    // WIDTH+1 positions. Each level walks downward so i-d still holds the
    // previous level's (G,P).
    always_comb begin
        w_g    = A & B;
        w_p    = w_p0;
        w_g[0] = w_g[0] | (w_p0[0] & Cin);
        for (int l = 0; l < c_LEVELS; l++) begin
            for (int i = WIDTH - 1; i >= (1 << l); i--) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end
    end

    assign w_carry = {w_g[WIDTH-2:0], Cin};
    assign w_sum   = w_p0 ^ w_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign Sum = r_sum;

`ifdef PCFA2C_FLAGS_EN
    logic r_cout;
    logic r_ovf;
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_cout <= w_g[WIDTH-1];
            r_ovf  <= w_g[WIDTH-1] ^ w_carry[WIDTH-1];
            r_zero <= ~|w_sum;
        end
    end

    assign Cout = r_cout;
    assign Ovf  = r_ovf;
    assign Zero = r_zero;
`else
    assign Cout = 1'b0;
    assign Ovf  = 1'b0;
    assign Zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcfa2c_prefix_adder.sv
// ============================================================================
// Module   : tb_pcfa2c_prefix_adder
// Brief    : Directed self-checking bench for pcfa2c_prefix_adder (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pcfa2c_prefix_adder;

`ifdef PCFA2C_FLAGS_EN
    localparam bit c_FLAGS = 1'b1;
`else
    localparam bit c_FLAGS = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic [7:0] Sum;
    logic       Cout;
    logic       Ovf;
    logic       Zero;

    int n_cmp;
    int n_bad;

    pcfa2c_prefix_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .Sum (Sum),
        .Cout(Cout),
        .Ovf (Ovf),
        .Zero(Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and step past the capturing edge.
    task automatic drive(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic ci);
        rst = r;
        A   = a;
        B   = b;
        Cin = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'h5a, 8'ha5, 1'b1);
            n_cmp += 4;
            if (Sum !== 8'h00) begin n_bad++; $display("FAIL reset_sum: got %h want 00", Sum); end
            if (Cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", Cout); end
            if (Ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", Ovf); end
            if (Zero !== c_FLAGS) begin n_bad++; $display("FAIL reset_zero: got %b want %b", Zero, c_FLAGS); end
        end
        // 5a + a5 + 1 = 0x100
        drive(1'b0, 8'h5a, 8'ha5, 1'b1);
        n_cmp += 4;
        if (Sum !== 8'h00) begin n_bad++; $display("FAIL release_sum: got %h want 00", Sum); end
        if (Cout !== c_FLAGS) begin n_bad++; $display("FAIL release_cout: got %b want %b", Cout, c_FLAGS); end
        if (Ovf !== 1'b0) begin n_bad++; $display("FAIL release_ovf: got %b want 0", Ovf); end
        if (Zero !== c_FLAGS) begin n_bad++; $display("FAIL release_zero: got %b want %b", Zero, c_FLAGS); end
    endtask

    // Hand-computed vectors: {a, b, cin, sum, cout, ovf, zero}
    task automatic test_directed();
        logic [7:0] va  [10];
        logic [7:0] vb  [10];
        logic       vci [10];
        logic [7:0] vs  [10];
        logic       vc  [10];
        logic       vo  [10];
        logic       vz  [10];
        va = '{8'hff, 8'h01, 8'h04, 8'h04, 8'h7f, 8'h80, 8'hff, 8'h80, 8'h7f, 8'h00};
        vb = '{8'h02, 8'hfc, 8'h04, 8'hfb, 8'h00, 8'hff, 8'h01, 8'h80, 8'h7f, 8'h00};
        vci = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vs = '{8'h01, 8'hfd, 8'h08, 8'h00, 8'h80, 8'h7f, 8'h00, 8'h00, 8'hff, 8'h00};
        vc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, va[k], vb[k], vci[k]);
            n_cmp += 4;
            if (Sum !== vs[k]) begin n_bad++; $display("FAIL dir%0d_sum: got %h want %h", k, Sum, vs[k]); end
            if (Cout !== (vc[k] & c_FLAGS)) begin n_bad++; $display("FAIL dir%0d_cout: got %b want %b", k, Cout, vc[k] & c_FLAGS); end
            if (Ovf !== (vo[k] & c_FLAGS)) begin n_bad++; $display("FAIL dir%0d_ovf: got %b want %b", k, Ovf, vo[k] & c_FLAGS); end
            if (Zero !== (vz[k] & c_FLAGS)) begin n_bad++; $display("FAIL dir%0d_zero: got %b want %b", k, Zero, vz[k] & c_FLAGS); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       r;
        logic [8:0] full;
        logic [7:0] es;
        logic       ec;
        logic       eo;
        logic       ez;
        for (int k = 0; k < 12; k++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = k[0];
            r  = (k == 5);
            drive(r, a, b, ci);
            full = {1'b0, a} + {1'b0, b} + {8'h00, ci};
            if (r) begin
                es = 8'h00; ec = 1'b0; eo = 1'b0; ez = c_FLAGS;
            end else begin
                es = full[7:0];
                ec = full[8] & c_FLAGS;
                eo = (a[7] == b[7]) && (full[7] != a[7]) && c_FLAGS;
                ez = (full[7:0] == 8'h00) && c_FLAGS;
            end
            n_cmp += 4;
            if (Sum !== es) begin n_bad++; $display("FAIL b2b%0d_sum: a=%h b=%h cin=%b rst=%b got %h want %h", k, a, b, ci, r, Sum, es); end
            if (Cout !== ec) begin n_bad++; $display("FAIL b2b%0d_cout: got %b want %b", k, Cout, ec); end
            if (Ovf !== eo) begin n_bad++; $display("FAIL b2b%0d_ovf: got %b want %b", k, Ovf, eo); end
            if (Zero !== ez) begin n_bad++; $display("FAIL b2b%0d_zero: got %b want %b", k, Zero, ez); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        A   = 8'h00;
        B   = 8'h00;
        Cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
